dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder.
// Accepts one load/store at a time, waits LATENCY cycles, then presents a
// registered response until the requester takes it.
// Optional feature: define DMEM_ALIGN_CHK_EN to reject misaligned word
// accesses with resp_err instead of silently ignoring addr[1:0].
module dmem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         WORDS    = 1 << DEPTH_LOG2;
  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [3:0]              r_cnt;

  // Captured request, held unchanged through WAIT and RESP
  logic                    r_we;
  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;

  // Response registers, loaded on the edge entering RESP
  logic [31:0]             r_rdata;
  logic                    r_err;

  // Word storage; deliberately never cleared
  logic [31:0]             r_mem [WORDS];

  logic                    w_accept;
  logic                    w_commit;
  logic                    w_in_idle;
  logic                    w_op_we;
  logic [31:0]             w_op_addr;
  logic [31:0]             w_op_wdata;
  logic [DEPTH_LOG2-1:0]   w_idx;
  logic                    w_misaligned;
  logic                    w_unused_addr;

  assign w_in_idle = (r_state == S_IDLE);
  assign w_accept  = w_in_idle && req_valid;

  // With zero latency the commit happens on the accept edge itself, so the
  // operation has to come straight from the request inputs in IDLE.
  assign w_commit   = (w_accept && ZERO_LAT) || ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_op_we    = w_in_idle ? req_we    : r_we;
  assign w_op_addr  = w_in_idle ? req_addr  : r_addr;
  assign w_op_wdata = w_in_idle ? req_wdata : r_wdata;

  // Upper address bits fall off here, so the address space wraps.
  assign w_idx = w_op_addr[DEPTH_LOG2+1:2];

`ifdef DMEM_ALIGN_CHK_EN
  assign w_misaligned = (w_op_addr[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_unused_addr = ^{w_op_addr[31:DEPTH_LOG2+2], w_op_addr[1:0]};

  // State register plus wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept && !ZERO_LAT) begin
        r_cnt <= LAT_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid)      w_state_next = ZERO_LAT ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0)  w_state_next = S_RESP;
      S_RESP:  if (resp_ready)     w_state_next = S_IDLE;
      default:                     w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs depend on state only
  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
  end

  // Capture the request on accept; later request inputs are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Register the response on the edge entering RESP; stores and rejected
  // accesses return zero data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_rdata <= (w_op_we || w_misaligned) ? 32'd0 : r_mem[w_idx];
      r_err   <= w_misaligned;
    end
  end

  // Store commit; no reset so the array stays RAM-mappable. A store aborted
  // in WAIT never reaches this edge because reset has already forced IDLE.
  always_ff @(posedge clk) begin
    if (w_commit && w_op_we && !w_misaligned) begin
      r_mem[w_idx] <= w_op_wdata;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
